// File: rtl/regfile_dump_pkg.sv
// rtl/regfile_dump_pkg.sv - shared types and constants for the register file dump reader
package regfile_dump_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        ADDR,
        DATA,
        CKSUM,
        DONE
    } dumpState_t;

    localparam logic [7:0] HDR_BYTE       = 8'hA5;
    localparam int         BYTES_PER_WORD = 4;

endpackage

// File: rtl/regfile_dump.sv
// rtl/regfile_dump.sv - walks a register range and streams it as a framed, checksummed byte packet
module regfile_dump
    import regfile_dump_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Start,
    input  logic [ADDR_W-1:0] FirstReg,
    input  logic [ADDR_W-1:0] LastReg,
    output logic [ADDR_W-1:0] DumpReg,
    input  logic [DATA_W-1:0] DumpData,
    output logic [7:0]        ByteOut,
    output logic              ByteValid,
    input  logic              ByteReady,
    output logic              Busy,
    output logic              Done
);

    dumpState_t        state;
    dumpState_t        nextState;

    logic [ADDR_W-1:0] lastReg;
    logic              emptyRange;
    logic [DATA_W-1:0] shiftReg;
    logic [1:0]        byteIdx;
    logic [7:0]        checksum;

    logic [7:0]        nByteOut;
    logic              nByteValid;
    logic [ADDR_W-1:0] nDumpReg;
    logic [ADDR_W-1:0] nLastReg;
    logic              nEmptyRange;
    logic [DATA_W-1:0] nShiftReg;
    logic [1:0]        nByteIdx;
    logic [7:0]        nChecksum;

    logic              xfer;
    logic              lastByte;
    logic              atLastReg;
    logic [ADDR_W-1:0] incReg;
    logic [7:0]        dataCs;

    assign xfer      = ByteValid && ByteReady;
    assign lastByte  = (byteIdx == 2'(BYTES_PER_WORD - 1));
    assign atLastReg = (DumpReg == lastReg);
    assign incReg    = DumpReg + ADDR_W'(1);
    // In DATA the byte on the wire is always shiftReg[7:0], so fold that into the checksum.
    assign dataCs    = checksum ^ shiftReg[7:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (Start) nextState = HDR;
            HDR:     if (xfer) nextState = emptyRange ? CKSUM : ADDR;
            ADDR:    if (xfer) nextState = DATA;
            DATA:    if (xfer && lastByte) nextState = atLastReg ? CKSUM : ADDR;
            CKSUM:   if (xfer) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Next-value logic for the registered stream outputs and the walk datapath.
    always_comb begin
        nByteOut    = ByteOut;
        nByteValid  = ByteValid;
        nDumpReg    = DumpReg;
        nLastReg    = lastReg;
        nEmptyRange = emptyRange;
        nShiftReg   = shiftReg;
        nByteIdx    = byteIdx;
        nChecksum   = checksum;
        case (state)
            IDLE: begin
                if (Start) begin
                    nByteOut    = HDR_BYTE;
                    nByteValid  = 1'b1;
                    nDumpReg    = FirstReg;
                    nLastReg    = LastReg;
                    nEmptyRange = (FirstReg > LastReg);
                    nChecksum   = 8'h00;
                end
            end
            HDR: begin
                if (xfer) begin
                    nByteOut = emptyRange ? checksum : 8'(DumpReg);
                end
            end
            ADDR: begin
                if (xfer) begin
                    nChecksum = checksum ^ ByteOut;
                    nShiftReg = DumpData;
                    nByteIdx  = 2'd0;
                    nByteOut  = DumpData[7:0];
                end
            end
            DATA: begin
                if (xfer) begin
                    nChecksum = dataCs;
                    if (lastByte) begin
                        if (atLastReg) begin
                            nByteOut = dataCs;
                        end else begin
                            nDumpReg = incReg;
                            nByteOut = 8'(incReg);
                        end
                    end else begin
                        nShiftReg = shiftReg >> 8;
                        nByteIdx  = byteIdx + 2'd1;
                        nByteOut  = shiftReg[15:8];
                    end
                end
            end
            CKSUM: begin
                if (xfer) begin
                    nByteValid = 1'b0;
                    nByteOut   = 8'h00;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ByteOut    <= 8'h00;
            ByteValid  <= 1'b0;
            DumpReg    <= '0;
            lastReg    <= '0;
            emptyRange <= 1'b0;
            shiftReg   <= '0;
            byteIdx    <= 2'd0;
            checksum   <= 8'h00;
        end else begin
            ByteOut    <= nByteOut;
            ByteValid  <= nByteValid;
            DumpReg    <= nDumpReg;
            lastReg    <= nLastReg;
            emptyRange <= nEmptyRange;
            shiftReg   <= nShiftReg;
            byteIdx    <= nByteIdx;
            checksum   <= nChecksum;
        end
    end

    assign Busy = (state != IDLE);
    assign Done = (state == DONE);

endmodule

// File: tb/tb_regfile_dump.sv
// tb/tb_regfile_dump.sv - directed bench for regfile_dump with a behavioural register file
module tb_regfile_dump;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        Start = 1'b0;
    logic [4:0]  FirstReg = 5'd0;
    logic [4:0]  LastReg = 5'd0;
    logic [4:0]  DumpReg;
    logic [31:0] DumpData;
    logic [7:0]  ByteOut;
    logic        ByteValid;
    logic        ByteReady = 1'b0;
    logic        Busy;
    logic        Done;

    logic [31:0] regs [32];
    logic [31:0] expVals [32];
    logic [7:0]  rxBytes [$];
    logic [7:0]  expBytes [$];

    int nCompared = 0;
    int nMismatched = 0;
    int dc;
    int bc;

    always #5 clk = ~clk;

    assign DumpData = (DumpReg == 5'd0) ? 32'd0 : regs[DumpReg];

    regfile_dump #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .Start     (Start),
        .FirstReg  (FirstReg),
        .LastReg   (LastReg),
        .DumpReg   (DumpReg),
        .DumpData  (DumpData),
        .ByteOut   (ByteOut),
        .ByteValid (ByteValid),
        .ByteReady (ByteReady),
        .Busy      (Busy),
        .Done      (Done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rxAt(input int i);
        if (i < rxBytes.size()) return rxBytes[i];
        return 8'hxx;
    endfunction

    task automatic initRegs();
        for (int n = 0; n < 32; n++) begin
            regs[n]    = 32'h1000_0000 + n;
            expVals[n] = (n == 0) ? 32'd0 : 32'h1000_0000 + n;
        end
    endtask

    task automatic buildExpected(input int first, input int last);
        logic [7:0] cs;
        logic [7:0] b;
        expBytes.delete();
        expBytes.push_back(8'hA5);
        cs = 8'h00;
        for (int r = first; r <= last; r++) begin
            b = 8'(r);
            expBytes.push_back(b);
            cs ^= b;
            for (int k = 0; k < 4; k++) begin
                b = expVals[r][8*k +: 8];
                expBytes.push_back(b);
                cs ^= b;
            end
        end
        expBytes.push_back(cs);
    endtask

    task automatic compareFrame(input string tag);
        check($sformatf("%s.len", tag), rxBytes.size(), expBytes.size());
        for (int i = 0; i < expBytes.size() && i < rxBytes.size(); i++)
            check($sformatf("%s[%0d]", tag, i), rxBytes[i], expBytes[i]);
    endtask

    // bpMode 1 randomises ByteReady and pokes Start mid-frame; writeAt/resetAt trigger after that many bytes.
    task automatic runDump(input logic [4:0] first, input logic [4:0] last, input int bpMode,
                           input int writeAt, input int resetAt, output int doneCyc, output int busyCyc);
        bit         prevStall;
        bit         written;
        bit         aborted;
        logic [7:0] prevByte;
        rxBytes.delete();
        doneCyc = -1;
        busyCyc = 0;
        prevStall = 0;
        written = 0;
        aborted = 0;
        prevByte = 8'h00;
        @(negedge clk);
        FirstReg = first;
        LastReg = last;
        Start = 1'b1;
        for (int cyc = 1; cyc <= 2000; cyc++) begin
            @(negedge clk);
            if (cyc == 1) Start = 1'b0;
            if (bpMode == 1 && cyc == 10) begin
                Start = 1'b1;
                FirstReg = 5'd20;
                LastReg = 5'd21;
            end
            if (bpMode == 1 && cyc == 11) Start = 1'b0;
            if (writeAt > 0 && !written && rxBytes.size() >= writeAt) begin
                regs[4] = 32'hCAFE_BABE;
                regs[9] = 32'h9999_0009;
                written = 1;
            end
            if (resetAt > 0 && rxBytes.size() >= resetAt) begin
                reset = 1'b1;
                @(negedge clk);
                #1;
                check("rstValid", ByteValid, 1'b0);
                check("rstBusy", Busy, 1'b0);
                check("rstDone", Done, 1'b0);
                check("rstByte", ByteOut, 8'h00);
                check("rstDumpReg", DumpReg, 5'd0);
                reset = 1'b0;
                aborted = 1;
                break;
            end
            ByteReady = (bpMode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (prevStall) begin
                check("stallValid", ByteValid, 1'b1);
                check("stallByte", ByteOut, prevByte);
            end
            if (Done) begin
                doneCyc = cyc;
                if (Busy) busyCyc++;
                break;
            end
            if (Busy) busyCyc++;
            if (ByteValid && ByteReady) rxBytes.push_back(ByteOut);
            prevStall = ByteValid && !ByteReady;
            prevByte = ByteOut;
        end
        if (!aborted) begin
            check("doneSeen", doneCyc > 0, 1'b1);
            @(negedge clk);
            #1;
            check("donePulse", Done, 1'b0);
            check("idleAfter", Busy, 1'b0);
        end
    endtask

    initial begin
        logic [7:0] single [7];
        single = '{8'hA5, 8'h05, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h27};
        initRegs();

        repeat (3) @(negedge clk);
        #1;
        check("resetValid", ByteValid, 1'b0);
        check("resetBusy", Busy, 1'b0);
        check("resetDone", Done, 1'b0);
        check("resetByte", ByteOut, 8'h00);
        check("resetDumpReg", DumpReg, 5'd0);
        reset = 1'b0;

        runDump(5'd0, 5'd31, 0, 0, 0, dc, bc);
        buildExpected(0, 31);
        compareFrame("full");
        check("fullDoneCyc", dc, 163);
        check("fullBusy", bc, 163);
        for (int i = 1; i <= 5; i++) check("fullR0", rxAt(i), 8'h00);
        check("fullR1a", rxAt(6), 8'h01);
        check("fullR1b0", rxAt(7), 8'h01);
        check("fullR1b1", rxAt(8), 8'h00);
        check("fullR1b2", rxAt(9), 8'h00);
        check("fullR1b3", rxAt(10), 8'h10);
        check("fullCksum", rxAt(161), 8'h10);

        regs[5] = 32'hDEAD_BEEF;
        runDump(5'd5, 5'd5, 0, 0, 0, dc, bc);
        check("singleLen", rxBytes.size(), 7);
        for (int i = 0; i < 7; i++) check($sformatf("single[%0d]", i), rxAt(i), single[i]);
        check("singleBusy", bc, 8);
        check("singleDoneCyc", dc, 8);

        initRegs();
        runDump(5'd0, 5'd31, 1, 0, 0, dc, bc);
        buildExpected(0, 31);
        compareFrame("bp");

        runDump(5'd7, 5'd3, 0, 0, 0, dc, bc);
        check("emptyLen", rxBytes.size(), 2);
        check("emptyHdr", rxAt(0), 8'hA5);
        check("emptyCksum", rxAt(1), 8'h00);
        check("emptyDoneCyc", dc, 3);

        initRegs();
        expVals[9] = 32'h9999_0009;
        runDump(5'd3, 5'd10, 0, 7, 0, dc, bc);
        buildExpected(3, 10);
        compareFrame("coh");
        check("cohR4b0", rxAt(7), 8'h04);
        check("cohR4b3", rxAt(10), 8'h10);
        check("cohR9a", rxAt(31), 8'h09);
        check("cohR9b3", rxAt(35), 8'h99);

        initRegs();
        runDump(5'd0, 5'd31, 0, 0, 40, dc, bc);
        runDump(5'd0, 5'd31, 0, 0, 0, dc, bc);
        buildExpected(0, 31);
        compareFrame("afterRst");
        check("afterRstDoneCyc", dc, 163);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/regfile_dump.md
# regfile_dump

Debug reader for the 32×32 register file. On a start pulse it walks a register range through a dedicated read port and streams each register out as a framed, byte-serial packet over a valid/ready interface. The packet carries a header, then an address byte and four data bytes per register, then an XOR checksum. It sits beside the datapath and feeds the debug UART transmitter, and it never writes the register file.

## Interface
- NUM_REGS, 32, number of architectural registers
- ADDR_W, 5, register address width
- DATA_W, 32, register data width (must be 32; four bytes per word)
- clk  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- Start  in  1  begin a dump; sampled only in IDLE
- FirstReg  in  ADDR_W  first register of range, latched on Start
- LastReg  in  ADDR_W  last register of range (inclusive), latched on Start
- DumpReg  out  ADDR_W  address to the register file read port
- DumpData  in  DATA_W  combinational read data for DumpReg (register 0 reads 0)
- ByteOut  out  8  stream byte
- ByteValid  out  1  ByteOut is valid
- ByteReady  in  1  sink accepts the byte
- Busy  out  1  frame in progress
- Done  out  1  one-cycle pulse after the final byte transfers

## Operation
- Transfer occurs on any cycle with ByteValid && ByteReady.
- Frame layout: 0xA5, then for each reg r from FirstReg to LastReg: {3'b0, r}, D[7:0], D[15:8], D[23:16], D[31:24], then checksum.
- Checksum is the XOR of every address and data byte. The header is excluded.
- If FirstReg > LastReg, the frame is 0xA5 followed by checksum 0x00.
- State machine:
  - IDLE → HDR on Start: latch range, set DumpReg=FirstReg, clear checksum.
  - HDR → ADDR on transfer, or HDR → CKSUM if the range is empty.
  - ADDR → DATA on transfer. The same edge captures DumpData into a 32-bit shift register and the byte index is set to 0.
  - DATA: each transfer shifts right 8 bits. After byte 3: if DumpReg==LastReg go to CKSUM, else DumpReg+1 and go to ADDR.
  - CKSUM → DONE on transfer.
  - DONE → IDLE unconditionally. Done=1 for this cycle.
- ByteOut and ByteValid are registered outputs. They stay stable while ByteValid=1 and ByteReady=0.
- Start while Busy is ignored.
- Coherency:
  - A register is sampled when its address byte transfers. Later writes to it do not alter the bytes already emitted.
  - Writes to registers not yet sampled are reflected. The frame is not an atomic snapshot.
- LastReg=31 must not overflow DumpReg. The compare happens before the increment.
- Reset, including mid-frame: next cycle state=IDLE, ByteValid=0, ByteOut=0, Busy=0, Done=0, DumpReg=0, checksum=0. Any partial frame is abandoned.

## Timing
- Start sampled at edge N → ByteValid=1 with 0xA5 from cycle N+1. Busy=1 from N+1 through the DONE cycle.
- With ByteReady held high, one byte transfers per cycle with no bubbles. A range of K registers takes 5K+2 transfer cycles plus one DONE cycle.
- Back-pressure stalls the FSM with zero loss and no duplication.
- DumpReg is registered. It is stable for at least one full cycle before the capturing edge.
- Busy=0 in the DONE cycle's successor. A new Start is accepted the cycle after Done.

## Structure
- Shared package regfile_dump_pkg holds:
  - state enum: IDLE, HDR, ADDR, DATA, CKSUM, DONE
  - HDR_BYTE = 8'hA5
  - BYTES_PER_WORD = 4
- Single module, no sub-modules. Address counter, byte index, shift register and checksum are all local.
- The register file is instantiated at the top level with its second read port (or a third, debug read port) driven by DumpReg.

## Test plan
- Full dump: registers preloaded with Rn = 0x1000_0000+n, FirstReg=0, LastReg=31, ByteReady=1.
  - Expect 162 bytes: 0xA5, then 0x00,00,00,00,00, then 0x01,01,00,00,10 … .
  - Correct XOR checksum; Done 163 cycles after Start.
- Single register: First=Last=5, R5=0xDEADBEEF.
  - Expect A5 05 EF BE AD DE then checksum 0x05^0xEF^0xBE^0xAD^0xDE=0x27; Busy for 8 cycles.
- Back-pressure: ByteReady toggles pseudo-randomly over the full dump.
  - Byte sequence identical to the first test; ByteOut stable while stalled.
- Empty range: First=7, Last=3 → A5 00, then Done.
- Coherency:
  - A write to R4 after R4's address byte transfers → emitted R4 bytes are the old value.
  - A write to R9 before it is reached → new value is emitted.
- Reset mid-frame at byte 40, then Start is ignored while Busy.
  - Next cycle ByteValid=0, Busy=0.
  - A fresh Start produces a complete, correct frame.
